// File: rtl/axi4_stream_demux_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_demux_ctl_pkg
//  Purpose  : Shared types and helpers for the AXI4-Stream demux sequencer.
//             - ctl_state_e   : sequencer state encoding (IDLE / RUN / STOP)
//             - RR_MAX        : widest mask the round-robin helper accepts
//             - rr_next_idx() : next enabled index strictly after `cur`,
//                               wrapping; returns `cur` when it is the only
//                               set bit, and `cur` unchanged for an empty mask
//  Revision : 1.0 - initial release
// ============================================================================
package axi4_stream_demux_ctl_pkg;

  localparam int RR_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } ctl_state_e;

  // Candidates are scanned from the farthest (cur itself, k == sn) to the
  // nearest (k == 1); the last hit wins, so the result is the first enabled
  // index after cur in circular order. The loop bound is a constant so the
  // function unrolls cleanly in synthesis.
  function automatic int rr_next_idx(input logic [RR_MAX-1:0] msk,
                                     input int sn,
                                     input int cur);
    int res;
    int idx;
    res = cur;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= sn) begin
        idx = (cur + k) % sn;
        if (msk[idx]) res = idx;
      end
    end
    return res;
  endfunction

endpackage : axi4_stream_demux_ctl_pkg
`default_nettype wire

// File: rtl/axi4_stream_rr_next.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_rr_next
//  Purpose  : Combinational round-robin finder.
//  Ports    : msk_i [SN] - enable mask
//             cur_i [SW] - current index
//             nxt_o [SW] - next enabled index after cur_i (wrapping)
//             any_o      - at least one mask bit set
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_stream_rr_next
  import axi4_stream_demux_ctl_pkg::*;
#(
  parameter int SN = 2,
  parameter int SW = $clog2(SN)
) (
  input  logic [SN-1:0] msk_i,
  input  logic [SW-1:0] cur_i,
  output logic [SW-1:0] nxt_o,
  output logic          any_o
);

  logic [RR_MAX-1:0] msk_ext;

  assign msk_ext = RR_MAX'(msk_i);
  assign nxt_o   = SW'(rr_next_idx(msk_ext, SN, int'(cur_i)));
  assign any_o   = |msk_i;

endmodule : axi4_stream_rr_next
`default_nettype wire

// File: rtl/axi4_stream_demux_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_demux_ctl
//  Purpose  : Sequencer for the AXI4-Stream demux select. Spreads consecutive
//             segments of the monitored stream round-robin over the enabled
//             demux outputs; a segment ends after cfg_len_i beats or on TLAST.
//  Ports    : clk_i, rstn_i (sync, active-low), ctl_rst_i/ctl_str_i/ctl_stp_i
//             control pulses, cfg_msk_i/cfg_len_i/cfg_lst_i configuration,
//             mon_vld_i/mon_rdy_i/mon_lst_i stream taps, sel_o demux select,
//             ena_o routing gate, sts_run_o/sts_cnt_o/sts_seg_o status.
//  Options  : AXI4_STREAM_DEMUX_CTL_STS_EN - per-port completed-segment
//             counters on sts_seg_o; otherwise sts_seg_o is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_stream_demux_ctl
  import axi4_stream_demux_ctl_pkg::*;
#(
  parameter int SN = 2,
  parameter int SW = $clog2(SN),
  parameter int CW = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ctl_rst_i,
  input  logic             ctl_str_i,
  input  logic             ctl_stp_i,
  input  logic [SN-1:0]    cfg_msk_i,
  input  logic [CW-1:0]    cfg_len_i,
  input  logic             cfg_lst_i,
  input  logic             mon_vld_i,
  input  logic             mon_rdy_i,
  input  logic             mon_lst_i,
  output logic [SW-1:0]    sel_o,
  output logic             ena_o,
  output logic             sts_run_o,
  output logic [CW-1:0]    sts_cnt_o,
  output logic [SN*CW-1:0] sts_seg_o
);

  ctl_state_e    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          ena_q, ena_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          clr;
  logic          running;
  logic          beat;
  logic          eos;
  logic          msk_any;
  logic [SW-1:0] nxt_idx;
  logic [SW-1:0] first_idx;

  // Hardware and software reset are interchangeable.
  assign clr     = !rstn_i || ctl_rst_i;
  assign running = (state_q != ST_IDLE);
  assign beat    = mon_vld_i && mon_rdy_i;

  // With cfg_len_i == 0 in count mode the segment never ends on count.
  assign eos = running && beat &&
               (cfg_lst_i ? mon_lst_i
                          : ((cfg_len_i != '0) && (cnt_q == cfg_len_i - CW'(1))));

  axi4_stream_rr_next #(
    .SN (SN),
    .SW (SW)
  ) u_rr_next (
    .msk_i (cfg_msk_i),
    .cur_i (sel_q),
    .nxt_o (nxt_idx),
    .any_o (msk_any)
  );

  // Starting the search just after the top index yields the lowest set bit.
  assign first_idx = SW'(rr_next_idx(RR_MAX'(cfg_msk_i), SN, SN - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ctl_str_i && !ctl_stp_i && msk_any) state_d = ST_RUN;
      ST_RUN: begin
        if (eos && (ctl_stp_i || !msk_any)) state_d = ST_IDLE;
        else if (ctl_stp_i)                 state_d = ST_STOP;
      end
      ST_STOP: if (eos) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. sel moves on the edge that completes the
  // eos beat, so the following beat already goes to the new port.
  always_comb begin
    sel_d = sel_q;
    ena_d = ena_q;
    cnt_d = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_RUN) begin
          sel_d = first_idx;
          ena_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_RUN, ST_STOP: begin
        if (eos) begin
          cnt_d = '0;
          if (state_d == ST_IDLE) ena_d = 1'b0;
          else                    sel_d = nxt_idx;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        ena_d = 1'b0;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      sel_q <= '0;
      ena_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      ena_q <= ena_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_o     = sel_q;
  assign ena_o     = ena_q;
  assign sts_run_o = running;
  assign sts_cnt_o = cnt_q;

`ifdef AXI4_STREAM_DEMUX_CTL_STS_EN
  // Segment is credited to the port that carried it (sel before update).
  for (genvar i = 0; i < SN; i++) begin : g_seg
    logic [CW-1:0] seg_q;
    always_ff @(posedge clk_i) begin
      if (clr)                            seg_q <= '0;
      else if (eos && (sel_q == SW'(i)))  seg_q <= seg_q + CW'(1);
    end
    assign sts_seg_o[i*CW +: CW] = seg_q;
  end
`else
  assign sts_seg_o = '0;
`endif

endmodule : axi4_stream_demux_ctl
`default_nettype wire

// File: tb/tb_axi4_stream_demux_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_stream_demux_ctl
//  Purpose  : Directed self-checking bench for axi4_stream_demux_ctl (SN=4).
//             Honours AXI4_STREAM_DEMUX_CTL_STS_EN for the segment counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_stream_demux_ctl;

  localparam int SN = 4;
  localparam int SW = 2;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rstn, ctl_rst, ctl_str, ctl_stp;
  logic [SN-1:0]    cfg_msk;
  logic [CW-1:0]    cfg_len;
  logic             cfg_lst, mon_vld, mon_rdy, mon_lst;
  logic [SW-1:0]    sel;
  logic             ena, sts_run;
  logic [CW-1:0]    sts_cnt;
  logic [SN*CW-1:0] sts_seg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_stream_demux_ctl #(.SN(SN), .SW(SW), .CW(CW)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .ctl_rst_i (ctl_rst),
    .ctl_str_i (ctl_str),
    .ctl_stp_i (ctl_stp),
    .cfg_msk_i (cfg_msk),
    .cfg_len_i (cfg_len),
    .cfg_lst_i (cfg_lst),
    .mon_vld_i (mon_vld),
    .mon_rdy_i (mon_rdy),
    .mon_lst_i (mon_lst),
    .sel_o     (sel),
    .ena_o     (ena),
    .sts_run_o (sts_run),
    .sts_cnt_o (sts_cnt),
    .sts_seg_o (sts_seg)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic soft_rst();
    ctl_rst = 1'b1; tick(); ctl_rst = 1'b0;
  endtask

  task automatic start();
    ctl_str = 1'b1; tick(); ctl_str = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ctl_str = 1'b1; cfg_msk = 4'b1111; mon_vld = 1'b1; mon_rdy = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (sel !== 2'd0)     begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (ena !== 1'b0)     begin failures++; $display("FAIL reset_ena got=%0b exp=0", ena); end
    checks++; if (sts_run !== 1'b0) begin failures++; $display("FAIL reset_run got=%0b exp=0", sts_run); end
    checks++; if (sts_cnt !== 0)    begin failures++; $display("FAIL reset_cnt got=%0d exp=0", sts_cnt); end
    checks++; if (sts_seg !== '0)   begin failures++; $display("FAIL reset_seg got=%0h exp=0", sts_seg); end
    rstn = 1'b1; ctl_str = 1'b0; mon_vld = 1'b0; mon_rdy = 1'b0;
    tick();
  endtask

  task automatic test_rr_count();
    logic [1:0] exp_sel [12];
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    soft_rst();
    cfg_msk = 4'b1011; cfg_len = 3; cfg_lst = 1'b0;
    start();
    mon_vld = 1'b1; mon_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (sel !== exp_sel[i]) begin failures++; $display("FAIL rr_sel beat=%0d got=%0d exp=%0d", i, sel, exp_sel[i]); end
      checks++; if (sts_cnt !== CW'(i % 3)) begin failures++; $display("FAIL rr_cnt beat=%0d got=%0d exp=%0d", i, sts_cnt, i % 3); end
      checks++; if (ena !== 1'b1 || sts_run !== 1'b1) begin failures++; $display("FAIL rr_ena beat=%0d got=%0b/%0b exp=1/1", i, ena, sts_run); end
      tick();
    end
    mon_vld = 1'b0; mon_rdy = 1'b0;
    @(negedge clk);
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL rr_sel_after got=%0d exp=1", sel); end
  endtask

  task automatic test_tlast();
    int bn;
    logic [1:0]    exp_sel;
    logic [CW-1:0] exp_cnt;
    soft_rst();
    cfg_msk = 4'b0011; cfg_len = 0; cfg_lst = 1'b1;
    start();
    bn = 0; exp_sel = 2'd0; exp_cnt = 0;
    mon_vld = 1'b1;
    for (int c = 0; c < 20; c++) begin
      mon_rdy = c[0];
      mon_lst = (bn == 4) || (bn == 6);
      @(negedge clk);
      checks++; if (sel !== exp_sel) begin failures++; $display("FAIL tlast_sel cyc=%0d got=%0d exp=%0d", c, sel, exp_sel); end
      checks++; if (sts_cnt !== exp_cnt) begin failures++; $display("FAIL tlast_cnt cyc=%0d got=%0d exp=%0d", c, sts_cnt, exp_cnt); end
      tick();
      if (mon_rdy) begin
        bn++;
        if (bn == 5)      begin exp_sel = 2'd1; exp_cnt = 0; end
        else if (bn == 7) begin exp_sel = 2'd0; exp_cnt = 0; end
        else              exp_cnt = exp_cnt + 1;
      end
    end
    mon_vld = 1'b0; mon_rdy = 1'b0; mon_lst = 1'b0;
  endtask

  task automatic test_stop();
    soft_rst();
    cfg_msk = 4'b0011; cfg_len = 4; cfg_lst = 1'b0;
    start();
    mon_vld = 1'b1; mon_rdy = 1'b1;
    @(negedge clk); tick();                        // beat 0
    ctl_stp = 1'b1;                                // beat 1 with stop
    @(negedge clk);
    checks++; if (sts_cnt !== 1) begin failures++; $display("FAIL stop_cnt1 got=%0d exp=1", sts_cnt); end
    tick(); ctl_stp = 1'b0;
    @(negedge clk);                                // beat 2
    checks++; if (ena !== 1'b1 || sts_run !== 1'b1) begin failures++; $display("FAIL stop_routing got=%0b/%0b exp=1/1", ena, sts_run); end
    checks++; if (sts_cnt !== 2) begin failures++; $display("FAIL stop_cnt2 got=%0d exp=2", sts_cnt); end
    tick();
    ctl_stp = 1'b1;                                // beat 3, repeated stop
    @(negedge clk);
    checks++; if (ena !== 1'b1 || sel !== 2'd0) begin failures++; $display("FAIL stop_last_beat got=%0b/%0d exp=1/0", ena, sel); end
    tick(); ctl_stp = 1'b0; mon_vld = 1'b0;
    @(negedge clk);
    checks++; if (ena !== 1'b0 || sts_run !== 1'b0) begin failures++; $display("FAIL stop_idle got=%0b/%0b exp=0/0", ena, sts_run); end
    checks++; if (sts_cnt !== 0) begin failures++; $display("FAIL stop_cnt_clr got=%0d exp=0", sts_cnt); end
    // eos coinciding with stop in RUN: straight to IDLE, sel holds
    cfg_len = 1;
    start();
    mon_vld = 1'b1;
    tick();                                        // beat -> sel 1
    ctl_stp = 1'b1;
    tick();                                        // eos + stop
    ctl_stp = 1'b0; mon_vld = 1'b0;
    @(negedge clk);
    checks++; if (sts_run !== 1'b0 || ena !== 1'b0) begin failures++; $display("FAIL eos_stp_idle got=%0b/%0b exp=0/0", sts_run, ena); end
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL eos_stp_sel got=%0d exp=1", sel); end
    mon_rdy = 1'b0;
  endtask

  task automatic test_mask();
    soft_rst();
    cfg_msk = 4'b0000; cfg_len = 2; cfg_lst = 1'b0;
    start();
    @(negedge clk);
    checks++; if (sts_run !== 1'b0 || ena !== 1'b0) begin failures++; $display("FAIL msk0_start got=%0b/%0b exp=0/0", sts_run, ena); end
    cfg_msk = 4'b0110;
    start();
    @(negedge clk);
    checks++; if (sel !== 2'd1 || ena !== 1'b1) begin failures++; $display("FAIL msk_first got=%0d/%0b exp=1/1", sel, ena); end
    mon_vld = 1'b1; mon_rdy = 1'b1;
    tick();
    cfg_msk = 4'b0000;
    tick();
    mon_vld = 1'b0;
    @(negedge clk);
    checks++; if (ena !== 1'b0 || sts_run !== 1'b0 || sts_cnt !== 0) begin failures++; $display("FAIL msk_clear got=%0b/%0b/%0d exp=0/0/0", ena, sts_run, sts_cnt); end
    mon_rdy = 1'b0;
  endtask

  task automatic test_ctl_rst();
    soft_rst();
    cfg_msk = 4'b1100; cfg_len = 5; cfg_lst = 1'b0;
    start();
    @(negedge clk);
    checks++; if (sel !== 2'd2) begin failures++; $display("FAIL crst_first got=%0d exp=2", sel); end
    mon_vld = 1'b1; mon_rdy = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (sts_cnt !== 2) begin failures++; $display("FAIL crst_cnt got=%0d exp=2", sts_cnt); end
    ctl_rst = 1'b1;
    tick();
    ctl_rst = 1'b0; mon_vld = 1'b0;
    @(negedge clk);
    checks++; if (sts_cnt !== 0 || ena !== 1'b0 || sel !== 2'd0 || sts_run !== 1'b0) begin failures++; $display("FAIL crst_clear got=%0d/%0b/%0d/%0b exp=0/0/0/0", sts_cnt, ena, sel, sts_run); end
    ctl_rst = 1'b1; ctl_str = 1'b1;
    tick();
    ctl_rst = 1'b0;
    @(negedge clk);
    checks++; if (sts_run !== 1'b0) begin failures++; $display("FAIL crst_priority got=%0b exp=0", sts_run); end
    tick();
    ctl_str = 1'b0;
    @(negedge clk);
    checks++; if (sel !== 2'd2 || ena !== 1'b1) begin failures++; $display("FAIL crst_restart got=%0d/%0b exp=2/1", sel, ena); end
    mon_rdy = 1'b0;
  endtask

  task automatic test_single();
    soft_rst();
    cfg_msk = 4'b0100; cfg_len = 1; cfg_lst = 1'b0;
    start();
    mon_vld = 1'b1; mon_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (sel !== 2'd2 || sts_cnt !== 0) begin failures++; $display("FAIL single_sel beat=%0d got=%0d/%0d exp=2/0", i, sel, sts_cnt); end
      tick();
    end
    mon_vld = 1'b0; mon_rdy = 1'b0;
  endtask

  task automatic test_seg();
    soft_rst();
    cfg_msk = 4'b0011; cfg_len = 2; cfg_lst = 1'b0;
    start();
    mon_vld = 1'b1; mon_rdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    mon_vld = 1'b0; mon_rdy = 1'b0;
    @(negedge clk);
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL seg_sel got=%0d exp=1", sel); end
`ifdef AXI4_STREAM_DEMUX_CTL_STS_EN
    checks++; if (sts_seg[0*CW +: CW] !== 3) begin failures++; $display("FAIL seg0 got=%0d exp=3", sts_seg[0*CW +: CW]); end
    checks++; if (sts_seg[1*CW +: CW] !== 2) begin failures++; $display("FAIL seg1 got=%0d exp=2", sts_seg[1*CW +: CW]); end
    checks++; if (sts_seg[2*CW +: 2*CW] !== '0) begin failures++; $display("FAIL seg23 got=%0h exp=0", sts_seg[2*CW +: 2*CW]); end
`else
    checks++; if (sts_seg !== '0) begin failures++; $display("FAIL seg_tied got=%0h exp=0", sts_seg); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; ctl_rst = 1'b0; ctl_str = 1'b0; ctl_stp = 1'b0;
    cfg_msk = '0; cfg_len = '0; cfg_lst = 1'b0;
    mon_vld = 1'b0; mon_rdy = 1'b0; mon_lst = 1'b0;
    test_reset();
    test_rr_count();
    test_tlast();
    test_stop();
    test_mask();
    test_ctl_rst();
    test_single();
    test_seg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axi4_stream_demux_ctl
`default_nettype wire
